fp13_conv_sched: RTL and testbench

FP13_CONV_SCHED -- requirements
Module: fp13_conv_sched

---
 rtl/fp13_conv_sched_pkg.sv | 30 +++
 rtl/fp13_conv_sched_rr_arb.sv | 30 +++
 rtl/fp13_conv_sched.sv | 112 +++++++++++
 tb/tb_fp13_conv_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fp13_conv_sched_pkg.sv
// Shared definitions for the sign-magnitude to fp13 conversion scheduler.
package fp13_conv_sched_pkg;

  // fp13 layout: [12] sign, [11:8] exponent, [7:0] fraction
  localparam int FP13_W   = 13;
  localparam int SIGN_BIT = 12;
  localparam int EXP_W    = 4;
  localparam int FRAC_W   = 8;

  // s8 operand layout: [7] sign, [6:0] magnitude
  localparam int S8_W  = 8;
  localparam int MAG_W = 7;

  localparam logic [EXP_W-1:0] EXP_ZERO = 4'd0;
  localparam logic [EXP_W-1:0] EXP_INIT = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_e;

  // The hidden-one is kept explicitly in frac[7]; the fraction LSB is always zero.
  function automatic logic [FP13_W-1:0] pack_fp13(input logic             sign,
                                                  input logic [EXP_W-1:0] exp,
                                                  input logic [MAG_W-1:0] mag);
    return {sign, exp, mag, 1'b0};
  endfunction

endpackage

// File: rtl/fp13_conv_sched_rr_arb.sv
// Round-robin arbiter: the first requester after 'last' wins.
module rr_arb #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx
);

  int   cand;
  logic found;

  // Scan ports in rotating order starting just past the last winner.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last) + k) % NREQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = 2'(cand);
      end
    end
  end

endmodule

// File: rtl/fp13_conv_sched.sv
// Arbitrated, one-at-a-time conversion of s8 sign-magnitude operands to fp13.
module fp13_conv_sched
  import fp13_conv_sched_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [S8_W*NREQ-1:0] req_s8,
  output logic [NREQ-1:0]     req_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP13_W-1:0]   out_fp13,
  output logic [1:0]          out_tag,
  output logic                busy
);

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic [MAG_W-1:0]   mag_q, mag_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [1:0]         tag_q, tag_d;
  // ptr_q is the port with highest priority for the next grant.
  logic [1:0]         ptr_q, ptr_d;

  logic [NREQ-1:0]    gnt;
  logic [1:0]         gnt_idx;
  logic [1:0]         last_idx;
  logic [S8_W-1:0]    op_sel;

  assign last_idx = (ptr_q == 2'd0) ? 2'(NREQ - 1) : (ptr_q - 2'd1);

  rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .last  (last_idx),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  // Select the granted port's operand.
  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == 2'(i)) op_sel = req_s8[S8_W*i +: S8_W];
    end
  end

  // Grant is only offered while idle; reset masks it immediately.
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_fp13  = pack_fp13(sign_q, exp_q, mag_q);
  assign out_tag   = tag_q;

  // Next-state: accept, normalize one bit per cycle, then hold for the consumer.
  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          sign_d  = op_sel[S8_W-1];
          mag_d   = op_sel[MAG_W-1:0];
          exp_d   = EXP_INIT;
          tag_d   = gnt_idx;
          ptr_d   = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : (gnt_idx + 2'd1);
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          exp_d   = EXP_ZERO;
          state_d = DONE;
        end else if (mag_q[MAG_W-1]) begin
          state_d = DONE;
        end else begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
          exp_d = exp_q - 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything visible at the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= EXP_ZERO;
      tag_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_fp13_conv_sched.sv
// Scoreboard bench for fp13_conv_sched with directed vectors.
module tb_fp13_conv_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_s8;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_fp13;
  logic [1:0]  out_tag;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit in_done = 0;

  typedef struct {
    logic [12:0] fp;
    logic [1:0]  tag;
    int          lat;
  } exp_t;
  exp_t q[$];

  fp13_conv_sched #(.NREQ(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_s8    (req_s8),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp13  (out_fp13),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_res(input logic [12:0] fp, input int tag, input int lat);
    exp_t e;
    e.fp  = fp;
    e.tag = 2'(tag);
    e.lat = lat;
    q.push_back(e);
  endtask

  // Wait for n accepts, then drop all request valids right after the last accept edge.
  task automatic accept_n(input int n);
    int got = 0;
    for (int t = 0; t < 400 && got < n; t++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) got++;
    end
    chk("accept_timeout", got, n);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic drive(input int p, input logic [7:0] v);
    @(posedge clk); #1;
    req_s8[p*8 +: 8] = v;
    req_valid[p]     = 1'b1;
    accept_n(1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 300; t++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic send(input int p, input logic [7:0] v, input logic [12:0] fp, input int lat);
    expect_res(fp, p, lat);
    drive(p, v);
    wait_drain();
  endtask

  // Monitor: grant order, latency, result fields and stability, one pop per handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (|(req_ready & req_valid)) begin
        acc_cyc = cyc;
        if (q.size() > 0) chk("grant", 32'(req_ready), 32'(2'b01 << q[0].tag));
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 0);
        end else begin
          if (!in_done) begin
            in_done = 1;
            chk("latency", cyc - acc_cyc, q[0].lat);
          end
          chk("out_fp13", 32'(out_fp13), 32'(q[0].fp));
          chk("out_tag", 32'(out_tag), 32'(q[0].tag));
          chk("req_ready_in_done", 32'(req_ready), 0);
          if (out_ready) begin
            void'(q.pop_front());
            in_done = 0;
          end
        end
      end
    end
  end

  initial begin
    int got;
    rst_n = 1'b0; req_valid = '0; req_s8 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    // Requests already pending while reset is held must not be granted.
    #1;
    req_s8    = {8'h81, 8'h40};
    req_valid = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_fp13", 32'(out_fp13), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_busy", 32'(busy), 0);

    // Both ports valid from reset: grants alternate starting at port 0.
    expect_res(13'h0780, 0, 2);
    expect_res(13'h1180, 1, 8);
    expect_res(13'h0780, 0, 2);
    expect_res(13'h1180, 1, 8);
    @(posedge clk); #1;
    rst_n = 1'b1;
    accept_n(4);
    wait_drain();

    // Directed single-port conversions.
    send(0, 8'h05, 13'h03A0, 6);
    send(0, 8'h80, 13'h1000, 2);
    send(0, 8'h00, 13'h0000, 2);
    send(1, 8'h81, 13'h1180, 8);
    send(0, 8'h40, 13'h0780, 2);
    send(1, 8'h7F, 13'h07FE, 2);
    send(0, 8'hFF, 13'h17FE, 2);
    send(1, 8'h02, 13'h0280, 7);

    // Consumer stalls in DONE while another port is waiting.
    out_ready = 1'b0;
    expect_res(13'h03A0, 0, 6);
    drive(0, 8'h05);
    expect_res(13'h1180, 1, 8);
    req_s8[15:8] = 8'h81;
    req_valid[1] = 1'b1;
    got = 0;
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    chk("stall_reach_done", 32'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 0);
      chk("stall_fp13", 32'(out_fp13), 32'h03A0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_release_grant", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain();

    // Reset in the middle of normalizing 8'h01 discards it and rewinds priority.
    drive(0, 8'h01);
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_out_fp13", 32'(out_fp13), 0);
    chk("mid_rst_out_tag", 32'(out_tag), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_no_valid", 32'(out_valid), 0);
    expect_res(13'h0780, 0, 2);
    expect_res(13'h1180, 1, 8);
    @(posedge clk); #1;
    req_s8    = {8'h81, 8'h40};
    req_valid = 2'b11;
    accept_n(2);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
